// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Writer side of the single-cycle core's instruction store. Accepts decoded
//   instruction fields over a valid/ready stream, rejects opcodes above BEQ,
//   packs each legal beat into a 9-bit word {type, opcode, operand} and writes
//   it to consecutive instruction-memory addresses starting at 0.
//
// Ports
//   Clk         in   sole clock, rising edge
//   Reset       in   synchronous, active-low
//   Start       in   begins a load session (honoured in IDLE/DONE/ERROR)
//   InValid     in   input beat valid
//   InReady     out  loader can accept a beat (registered)
//   InType      in   instruction type, 0 = R-type, 1 = I-type
//   InOp        in   4-bit opcode, 0000..1101 legal
//   InOperand   in   4-bit register/immediate field
//   InLast      in   current beat is the final instruction of the program
//   ImemWrEn    out  instruction-memory write strobe (registered)
//   ImemAddr    out  write address (registered)
//   ImemWrData  out  packed word {InType, InOp, InOperand} (registered)
//   Busy        out  high while a session is loading
//   Done        out  program loaded successfully (sticky)
//   Error       out  session aborted (sticky)
//   ErrCode     out  00 none, 01 illegal opcode, 10 overflow
//   Count       out  words written in the current session
// -----------------------------------------------------------------------------
module instr_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InType,
  input  logic [3:0]        InOp,
  input  logic [3:0]        InOperand,
  input  logic              InLast,
  output logic              ImemWrEn,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [8:0]        ImemWrData,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [1:0]        ErrCode,
  output logic [ADDR_W:0]   Count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [3:0]        OP_MAX  = 4'b1101;
  localparam logic [ADDR_W-1:0] PTR_TOP = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [1:0]        ERR_NONE    = 2'b00;
  localparam logic [1:0]        ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]        ERR_OVERFLOW = 2'b10;

  state_t              r_state,    w_state;
  logic [ADDR_W-1:0]   r_ptr,      w_ptr;
  logic                r_ready,    w_ready;
  logic                r_wr_en,    w_wr_en;
  logic [ADDR_W-1:0]   r_addr,     w_addr;
  logic [8:0]          r_wdata,    w_wdata;
  logic                r_done,     w_done;
  logic                r_error,    w_error;
  logic [1:0]          r_err_code, w_err_code;
  logic [ADDR_W:0]     r_count,    w_count;
  logic                w_accept;

  assign w_accept = InValid && r_ready;

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_ptr      = r_ptr;
    w_ready    = r_ready;
    w_wr_en    = 1'b0;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_done     = r_done;
    w_error    = r_error;
    w_err_code = r_err_code;
    w_count    = r_count;

    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          if (InOp <= OP_MAX) begin
            w_wr_en = 1'b1;
            w_addr  = r_ptr;
            w_wdata = {InType, InOp, InOperand};
            w_count = r_count + CNT_ONE;
            // Pointer saturates at the top address so it never wraps to 0.
            if (r_ptr != PTR_TOP) begin
              w_ptr = r_ptr + PTR_ONE;
            end
            if (InLast) begin
              w_state = S_DONE;
              w_done  = 1'b1;
              w_ready = 1'b0;
            end else if (r_ptr == PTR_TOP) begin
              // Top word is still written; the session then aborts.
              w_state    = S_ERROR;
              w_error    = 1'b1;
              w_err_code = ERR_OVERFLOW;
              w_ready    = 1'b0;
            end
          end else begin
            // Illegal opcode is consumed without a write, even on the last beat.
            w_state    = S_ERROR;
            w_error    = 1'b1;
            w_err_code = ERR_ILLEGAL;
            w_ready    = 1'b0;
          end
        end
      end
      default: begin
        if (Start) begin
          w_state    = S_LOAD;
          w_ptr      = '0;
          w_count    = '0;
          w_done     = 1'b0;
          w_error    = 1'b0;
          w_err_code = ERR_NONE;
          w_ready    = 1'b1;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_ready    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_count    <= '0;
    end else begin
      r_state    <= w_state;
      r_ptr      <= w_ptr;
      r_ready    <= w_ready;
      r_wr_en    <= w_wr_en;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_done     <= w_done;
      r_error    <= w_error;
      r_err_code <= w_err_code;
      r_count    <= w_count;
    end
  end

  assign InReady    = r_ready;
  assign ImemWrEn   = r_wr_en;
  assign ImemAddr   = r_addr;
  assign ImemWrData = r_wdata;
  assign Busy       = (r_state == S_LOAD);
  assign Done       = r_done;
  assign Error      = r_error;
  assign ErrCode    = r_err_code;
  assign Count      = r_count;

endmodule
